// File: rtl/ysyx_23060203_ifu_fetch_if.sv
// IFU bus bundle: imem request/response channel plus the IFU->IDU handshake.
interface ysyx_23060203_ifu_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output out_valid,
        output out_pc,
        output out_inst,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  out_valid,
        input  out_pc,
        input  out_inst,
        output out_ready
    );
endinterface

// File: rtl/ysyx_23060203_ifu_fetch.sv
// Pipelined instruction fetch with static JAL/backward-branch prediction.
// Define IFU_PERF_EN to add the fetch/stall/drop performance counters.
module ysyx_23060203_ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_dnpc,
    input  logic        jump_flush,
    input  logic [31:0] jump_dnpc,
    ysyx_23060203_ifu_fetch_if.master bus
`ifdef IFU_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_drop_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [31:0] fetch_pc;
    logic [31:0] fifo_pc   [DEPTH];
    logic [31:0] fifo_inst [DEPTH];
    ptr_t        fifo_rd;
    ptr_t        fifo_wr;
    cnt_t        fifo_cnt;
    logic [31:0] pend_pc   [DEPTH];
    ptr_t        pend_rd;
    ptr_t        pend_wr;
    cnt_t        inflight;
    logic [15:0] drop_cnt;

    logic        redirect;
    logic        req_fire;
    logic        rsp_drop;
    logic        rsp_live;
    logic        rsp_take;
    logic        pop;
    logic        is_jal;
    logic        is_br_t;
    logic        predict;
    logic        kill;
    logic [CW:0] occ;
    cnt_t        inflight_after;
    logic [31:0] inst;
    logic [31:0] rsp_pc;
    logic [31:0] imm_j;
    logic [31:0] imm_b;
    logic [31:0] target;

    assign redirect = flush | jump_flush;
    assign occ      = {1'b0, fifo_cnt} + {1'b0, inflight};

    assign bus.imem_req_valid = ~reset & ~redirect & (occ < LIMIT);
    assign bus.imem_req_addr  = fetch_pc;

    assign req_fire = bus.imem_req_valid & bus.imem_req_ready;
    assign rsp_drop = bus.imem_rsp_valid & (drop_cnt != 16'd0);
    assign rsp_live = bus.imem_rsp_valid & (drop_cnt == 16'd0);
    // A live response in a redirect cycle is wrong-path: counted, never enqueued.
    assign rsp_take = rsp_live & ~redirect;

    assign inst    = bus.imem_rsp_data;
    assign rsp_pc  = pend_pc[pend_rd];
    assign imm_j   = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_b   = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign is_jal  = inst[6:2] == 5'b11011;
    assign is_br_t = (inst[6:2] == 5'b11000) & inst[31];
    assign predict = rsp_take & (is_jal | is_br_t);
    assign target  = (rsp_pc + (is_jal ? imm_j : imm_b)) & ~32'h1;
    assign kill    = redirect | predict;

    assign inflight_after = inflight + cnt_t'(req_fire) - cnt_t'(rsp_live);

    assign bus.out_valid = ~reset & (fifo_cnt != '0) & ~redirect;
    assign bus.out_pc    = fifo_pc[fifo_rd];
    assign bus.out_inst  = fifo_inst[fifo_rd];
    assign pop           = bus.out_valid & bus.out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            fifo_rd  <= '0;
            fifo_wr  <= '0;
            fifo_cnt <= '0;
            pend_rd  <= '0;
            pend_wr  <= '0;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            // Everything still outstanding on a killed path returns as a drop.
            drop_cnt <= drop_cnt - 16'(rsp_drop)
                      + (kill ? 16'(inflight_after) : 16'd0);

            if (flush)
                fetch_pc <= flush_dnpc & ~32'h1;
            else if (jump_flush)
                fetch_pc <= jump_dnpc & ~32'h1;
            else if (predict)
                fetch_pc <= target;
            else if (req_fire)
                fetch_pc <= fetch_pc + 32'd4;

            if (kill) begin
                pend_rd  <= '0;
                pend_wr  <= '0;
                inflight <= '0;
            end else begin
                if (req_fire) begin
                    pend_pc[pend_wr] <= fetch_pc;
                    pend_wr          <= pend_wr + ptr_t'(1);
                end
                if (rsp_live)
                    pend_rd <= pend_rd + ptr_t'(1);
                inflight <= inflight_after;
            end

            if (redirect) begin
                fifo_rd  <= '0;
                fifo_wr  <= '0;
                fifo_cnt <= '0;
            end else begin
                if (rsp_take) begin
                    fifo_pc[fifo_wr]   <= rsp_pc;
                    fifo_inst[fifo_wr] <= inst;
                    fifo_wr            <= fifo_wr + ptr_t'(1);
                end
                if (pop)
                    fifo_rd <= fifo_rd + ptr_t'(1);
                fifo_cnt <= fifo_cnt + cnt_t'(rsp_take) - cnt_t'(pop);
            end
        end
    end

`ifdef IFU_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'(pop);
            perf_stall_cnt <= perf_stall_cnt
                            + 32'((fifo_cnt == '0) & ~redirect);
            perf_drop_cnt  <= perf_drop_cnt
                            + 32'(bus.imem_rsp_valid & ~rsp_take);
        end
    end
`endif
endmodule
